// File: rtl/bcd_digit_counter.sv
// rtl/bcd_digit_counter.sv - one clock digit: prescaler, modulo-N up/down counter, 7-segment decode
module bcd_digit_counter #(
  parameter int TICK_DIV     = 500000,
  parameter int MODULUS      = 10,
  parameter int USE_EXT_TICK = 0,
  parameter int PRE_W        = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pause_n,
  input  logic       clear,
  input  logic       lock,
  input  logic       down,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       tick_in,
  output logic       run,
  output logic [3:0] digit,
  output logic       carry_out,
  output logic [6:0] seg
);

  localparam logic [3:0]       TOP      = 4'(MODULUS - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic             sync1, sync2, sync_prev;
  logic             press;
  logic             user_clear, user_load;
  logic [PRE_W-1:0] pre, pre_next;
  logic             step;
  logic [3:0]       digit_next;
  logic             carry_next;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'h0:    seg_of = 7'b1000000;
      4'h1:    seg_of = 7'b1111001;
      4'h2:    seg_of = 7'b0100100;
      4'h3:    seg_of = 7'b0110000;
      4'h4:    seg_of = 7'b0011001;
      4'h5:    seg_of = 7'b0010010;
      4'h6:    seg_of = 7'b0000010;
      4'h7:    seg_of = 7'b1111000;
      4'h8:    seg_of = 7'b0000000;
      4'h9:    seg_of = 7'b0010000;
      4'hA:    seg_of = 7'b0001000;
      4'hB:    seg_of = 7'b0000011;
      4'hC:    seg_of = 7'b1000110;
      4'hD:    seg_of = 7'b0100001;
      4'hE:    seg_of = 7'b0000110;
      default: seg_of = 7'b0001110;
    endcase
  endfunction

  // The edge detector keeps sampling under lock so unlocking never fires a stale press.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      sync_prev <= 1'b1;
    end else begin
      sync1     <= pause_n;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign press      = sync_prev & ~sync2;
  assign user_clear = clear & ~lock;
  assign user_load  = load & ~lock;

  always_ff @(posedge clock) begin
    if (reset)
      run <= 1'b0;
    else if (press && !lock)
      run <= ~run;
  end

  always_comb begin
    pre_next = pre;
    step     = 1'b0;
    if (USE_EXT_TICK != 0) begin
      step = tick_in & run;
    end else if (run) begin
      if (pre == PRE_LAST) begin
        pre_next = '0;
        step     = 1'b1;
      end else begin
        pre_next = pre + PRE_W'(1);
      end
    end
    if (user_clear || user_load)
      pre_next = '0;
  end

  always_comb begin
    digit_next = digit;
    carry_next = 1'b0;
    if (user_clear) begin
      digit_next = 4'd0;
    end else if (user_load) begin
      digit_next = (load_val > TOP) ? TOP : load_val;
    end else if (step) begin
      if (down) begin
        if (digit == 4'd0) begin
          digit_next = TOP;
          carry_next = 1'b1;
        end else begin
          digit_next = digit - 4'd1;
        end
      end else begin
        if (digit == TOP) begin
          digit_next = 4'd0;
          carry_next = 1'b1;
        end else begin
          digit_next = digit + 4'd1;
        end
      end
    end
  end

  // seg is decoded from digit_next so it lines up with digit in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      pre       <= '0;
      digit     <= 4'd0;
      carry_out <= 1'b0;
      seg       <= 7'b1000000;
    end else begin
      pre       <= pre_next;
      digit     <= digit_next;
      carry_out <= carry_next;
      seg       <= seg_of(digit_next);
    end
  end

endmodule

// File: tb/tb_bcd_digit_counter.sv
// tb/tb_bcd_digit_counter.sv - chained units/tens digits checked against an arithmetic reference model
module tb_bcd_digit_counter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, pause_n, clear, lock, down, load;
  logic [3:0] load_val;
  logic       u_run, t_run, u_carry, t_carry;
  logic [3:0] u_digit, t_digit;
  logic [6:0] u_seg, t_seg;

  bcd_digit_counter #(.TICK_DIV(4), .MODULUS(10), .USE_EXT_TICK(0), .PRE_W(8)) u_units (
    .clock(clock), .reset(reset), .pause_n(pause_n), .clear(clear), .lock(lock), .down(down),
    .load(load), .load_val(load_val), .tick_in(1'b0), .run(u_run), .digit(u_digit),
    .carry_out(u_carry), .seg(u_seg));

  bcd_digit_counter #(.TICK_DIV(4), .MODULUS(6), .USE_EXT_TICK(1), .PRE_W(8)) u_tens (
    .clock(clock), .reset(reset), .pause_n(pause_n), .clear(clear), .lock(lock), .down(down),
    .load(load), .load_val(load_val), .tick_in(u_carry), .run(t_run), .digit(t_digit),
    .carry_out(t_carry), .seg(t_seg));

  int n_checks = 0;
  int n_fail   = 0;
  int m_run, m_pre, m_u, m_t, m_cu, m_ct;
  int h[3];
  int frozen;

  function automatic logic [6:0] seg_ref(input int v);
    case (v)
      0: seg_ref = 7'b1000000;   1: seg_ref = 7'b1111001;   2: seg_ref = 7'b0100100;
      3: seg_ref = 7'b0110000;   4: seg_ref = 7'b0011001;   5: seg_ref = 7'b0010010;
      6: seg_ref = 7'b0000010;   7: seg_ref = 7'b1111000;   8: seg_ref = 7'b0000000;
      9: seg_ref = 7'b0010000;  10: seg_ref = 7'b0001000;  11: seg_ref = 7'b0000011;
      12: seg_ref = 7'b1000110; 13: seg_ref = 7'b0100001;  14: seg_ref = 7'b0000110;
      default: seg_ref = 7'b0001110;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic adv(input int v, input int mod, input int st, output int nv, output int c);
    if (st == 0) begin
      nv = v; c = 0;
    end else if (down) begin
      c = (v == 0); nv = (v + mod - 1) % mod;
    end else begin
      c = (v == mod - 1); nv = (v + 1) % mod;
    end
  endtask

  // Reference: a press is seen when pause_n was high three edges back and low two edges back.
  task automatic model_edge();
    int tog, cl, ld, ustep, tstep, nu, nt, ncu, nct, npre;
    if (reset) begin
      m_run = 0; m_pre = 0; m_u = 0; m_t = 0; m_cu = 0; m_ct = 0;
      h = '{1, 1, 1};
    end else begin
      tog   = (h[2] == 1 && h[1] == 0 && !lock);
      cl    = clear && !lock;
      ld    = load && !lock;
      ustep = (m_run != 0) && m_pre == 3;
      tstep = (m_run != 0) && (m_cu != 0);
      if (cl) begin
        nu = 0; nt = 0; npre = 0; ncu = 0; nct = 0;
      end else if (ld) begin
        nu = (load_val > 9) ? 9 : int'(load_val);
        nt = (load_val > 5) ? 5 : int'(load_val);
        npre = 0; ncu = 0; nct = 0;
      end else begin
        npre = (m_run != 0) ? (m_pre + 1) % 4 : m_pre;
        adv(m_u, 10, ustep, nu, ncu);
        adv(m_t, 6, tstep, nt, nct);
      end
      h[2] = h[1]; h[1] = h[0]; h[0] = int'(pause_n);
      m_run = m_run ^ tog;
      m_pre = npre; m_u = nu; m_t = nt; m_cu = ncu; m_ct = nct;
    end
  endtask

  task automatic check_all();
    chk("u_run", u_run, m_run);
    chk("t_run", t_run, m_run);
    chk("u_digit", u_digit, m_u);
    chk("t_digit", t_digit, m_t);
    chk("u_carry", u_carry, m_cu);
    chk("t_carry", t_carry, m_ct);
    chk("u_seg", u_seg, seg_ref(m_u));
    chk("t_seg", t_seg, seg_ref(m_t));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic run_cycles(input int n);
    repeat (n) tick();
  endtask

  initial begin
    reset = 1; pause_n = 1; clear = 0; lock = 0; down = 0; load = 0; load_val = 0;
    tick(); tick();
    chk("reset_seg", u_seg, 7'b1000000);
    chk("reset_digit", u_digit, 0);
    chk("reset_run", u_run, 0);
    chk("reset_carry", u_carry, 0);
    reset = 0;

    // press -> run on the third edge
    pause_n = 0;
    tick(); chk("run_edge1", u_run, 0);
    tick(); chk("run_edge2", u_run, 0);
    tick(); chk("run_edge3", u_run, 1);
    pause_n = 1;
    for (int i = 0; i < 60 && u_carry !== 1'b1; i++) tick();
    chk("carry_seen", u_carry, 1);
    chk("wrap_digit", u_digit, 0);
    chk("wrap_seg", u_seg, 7'b1000000);
    tick();
    chk("carry_one_cycle", u_carry, 0);
    run_cycles(10);

    // pause with prescaler left at 2, long hold gives one toggle
    for (int i = 0; i < 8 && m_pre != 3; i++) tick();
    pause_n = 0;
    run_cycles(50);
    pause_n = 1;
    run_cycles(20);
    chk("paused_after_hold", u_run, 0);
    frozen = m_u;
    pause_n = 0;
    tick(); tick(); tick();
    chk("resumed", u_run, 1);
    pause_n = 1;
    tick(); chk("frozen_digit", u_digit, frozen);
    tick(); chk("resume_step", u_digit, (frozen + 1) % 10);

    // count down through zero on both digits
    down = 1; load_val = 0; load = 1;
    tick();
    load = 0;
    for (int i = 0; i < 8 && u_carry !== 1'b1; i++) tick();
    chk("down_wrap_digit", u_digit, 9);
    chk("down_wrap_carry", u_carry, 1);
    tick();
    chk("tens_down_wrap", t_digit, 5);
    chk("tens_down_carry", t_carry, 1);
    down = 0;

    // load clamp, then clear colliding with a wrapping step
    load_val = 4'd12; load = 1;
    tick();
    load = 0;
    chk("load_clamp_u", u_digit, 9);
    chk("load_clamp_t", t_digit, 5);
    for (int i = 0; i < 8 && m_pre != 3; i++) tick();
    clear = 1;
    tick();
    clear = 0;
    chk("clear_digit", u_digit, 0);
    chk("clear_carry", u_carry, 0);

    // lock freezes user controls; unlocking while held does not toggle
    lock = 1;
    pause_n = 0; run_cycles(5); pause_n = 1; run_cycles(3);
    chk("lock_run", u_run, 1);
    clear = 1; tick(); clear = 0;
    load_val = 3; load = 1; tick(); load = 0;
    pause_n = 0; run_cycles(4);
    lock = 0; run_cycles(4);
    pause_n = 1; run_cycles(4);
    chk("unlock_no_toggle", u_run, 1);

    // 59 -> 00 across the chain, then reset mid-count
    load_val = 9; load = 1;
    tick();
    load = 0;
    chk("load59_t", t_digit, 5);
    for (int i = 0; i < 8 && u_carry !== 1'b1; i++) tick();
    chk("chain_u_wrap", u_digit, 0);
    tick();
    chk("chain_t_wrap", t_digit, 0);
    chk("chain_t_carry", t_carry, 1);
    for (int i = 0; i < 40 && m_u != 7; i++) tick();
    chk("reached7", u_digit, 7);
    reset = 1;
    tick();
    reset = 0;
    chk("mid_reset_digit", u_digit, 0);
    chk("mid_reset_run", u_run, 0);
    chk("mid_reset_seg", u_seg, 7'b1000000);

    for (int i = 0; i < 400; i++) begin
      clear    = ($urandom_range(39) == 0);
      load     = ($urandom_range(29) == 0);
      load_val = 4'($urandom_range(15));
      if ($urandom_range(49) == 0) down = ~down;
      if ($urandom_range(59) == 0) lock = ~lock;
      if ($urandom_range(14) == 0) pause_n = ~pause_n;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
